// File: rtl/voxel_mem_arbiter_if.sv
// voxel_mem_arbiter_if: requester, scene-loader, clear-control and RAM-side signals of the voxel RAM arbiter.
interface voxel_mem_arbiter_if #(parameter int ADDR_BITS = 15);
    logic                 rd_req_a;
    logic                 rd_req_b;
    logic [ADDR_BITS-1:0] rd_addr_a;
    logic [ADDR_BITS-1:0] rd_addr_b;
    logic                 rd_gnt_a;
    logic                 rd_gnt_b;
    logic                 rd_valid_a;
    logic                 rd_valid_b;
    logic                 rd_data;
    logic                 wr_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic                 wr_data;
    logic                 wr_gnt;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 clr_done;
    logic [ADDR_BITS-1:0] ram_raddr;
    logic                 ram_rdata;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic                 ram_wdata;

    modport slave (
        input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b, wr_req, wr_addr, wr_data, clr_start, ram_rdata,
        output rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, rd_data, wr_gnt, clr_busy, clr_done,
               ram_raddr, ram_we, ram_waddr, ram_wdata
    );

    modport master (
        output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b, wr_req, wr_addr, wr_data, clr_start, ram_rdata,
        input  rd_gnt_a, rd_gnt_b, rd_valid_a, rd_valid_b, rd_data, wr_gnt, clr_busy, clr_done,
               ram_raddr, ram_we, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/voxel_mem_arbiter.sv
// voxel_mem_arbiter: round-robin read arbitration, write port and bulk clear engine in front of the voxel RAM.
module voxel_mem_arbiter #(
    parameter int ADDR_BITS = 15,
    parameter int RD_LAT    = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    voxel_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] cnt, cnt_nxt;
    logic [ADDR_BITS-1:0] raddr_q, waddr_q;
    logic                 wdata_q;
    logic                 last;
    logic [RD_LAT-1:0]    pv, pid;
    logic                 idle, clearing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == IDLE && bus.clr_start) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
        end else if (state == CLEAR) begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = (cnt == LAST_ADDR) ? DONE : CLEAR;
        end else if (state == DONE) begin
            state_nxt = IDLE;
        end
    end

    assign idle     = state == IDLE;
    assign clearing = state == CLEAR;

    // last=1 means B was granted most recently, so A wins the next tie
    assign bus.rd_gnt_a = idle & bus.rd_req_a & (~bus.rd_req_b | last);
    assign bus.rd_gnt_b = idle & bus.rd_req_b & (~bus.rd_req_a | ~last);
    assign bus.wr_gnt   = bus.wr_req & idle & ~bus.clr_start;

    assign bus.ram_raddr = bus.rd_gnt_a ? bus.rd_addr_a : bus.rd_gnt_b ? bus.rd_addr_b : raddr_q;
    assign bus.ram_we    = clearing | bus.wr_gnt;
    assign bus.ram_waddr = clearing ? cnt : bus.wr_gnt ? bus.wr_addr : waddr_q;
    assign bus.ram_wdata = ~clearing & (bus.wr_gnt ? bus.wr_data : wdata_q);

    assign bus.clr_busy   = clearing;
    assign bus.clr_done   = state == DONE;
    assign bus.rd_valid_a = pv[RD_LAT-1] & ~pid[RD_LAT-1];
    assign bus.rd_valid_b = pv[RD_LAT-1] & pid[RD_LAT-1];
    assign bus.rd_data    = pv[RD_LAT-1] & bus.ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= 1'b1;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
            pv      <= '0;
            pid     <= '0;
        end else begin
            if (bus.rd_gnt_a | bus.rd_gnt_b)
                last <= bus.rd_gnt_b;
            raddr_q <= bus.ram_raddr;
            waddr_q <= bus.ram_waddr;
            wdata_q <= bus.ram_wdata;
            pv      <= (pv << 1) | RD_LAT'(bus.rd_gnt_a | bus.rd_gnt_b);
            pid     <= (pid << 1) | RD_LAT'(bus.rd_gnt_b);
        end
    end
endmodule
